// File: rtl/key_matrix_pkg.sv
// Shared types and helpers for the key matrix scanner.
package key_matrix_pkg;

    // Scanner is either walking rows or presenting debounced events.
    typedef enum logic {
        SCAN   = 1'b0,
        REPORT = 1'b1
    } scan_state_t;

    // {row, col} event code width for the default 4x4 matrix.
    localparam int KEY_CODE_WIDTH = 4;

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic int lowest_set_bit(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/binary_decoder.sv
// Binary index to one-hot decoder, active-high outputs.
module binary_decoder #(
    parameter int WIDTH   = 2,
    parameter int OUTPUTS = 4
) (
    input  logic [WIDTH-1:0]   sel,
    output logic [OUTPUTS-1:0] onehot
);

    // Raise exactly the output selected by sel.
    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        onehot = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            if (sel == WIDTH'(i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Per-key debouncer: a state bit flips only after DEBOUNCE_SCANS
// consecutive samples that disagree with it.
module key_debounce
    import key_matrix_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DEBOUNCE_WIDTH = 3
) (
    input  logic clk,
    input  logic i_rst,
    input  logic sample_en,
    input  logic sample,
    output logic state,
    output logic changed
);

    localparam logic [DEBOUNCE_WIDTH-1:0] LAST = DEBOUNCE_WIDTH'(DEBOUNCE_SCANS - 1);

    logic [DEBOUNCE_WIDTH-1:0] count;

    // Flip happens on the edge where this sample completes the run.
    assign changed = sample_en && (sample != state) && (count == LAST);

    // Count consecutive disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (i_rst) begin
            count <= '0;
            state <= 1'b0;
        end else if (sample_en) begin
            if (sample == state) begin
                count <= '0;
            end else if (changed) begin
                state <= sample;
                count <= '0;
            end else begin
                count <= count + DEBOUNCE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// Row/column key matrix scanner with per-key debounce and a valid/ready
// press/release event stream. Events are never dropped: a stalled
// consumer freezes scanning.
// Optional: define KEY_MATRIX_GHOST_REJECT_EN to discard row samples that
// look like ghosting (>=2 active columns sharing a column with a key held
// in another row).
module key_matrix_scan
    import key_matrix_pkg::*;
#(
    parameter int NUM_ROWS              = 4,
    parameter int NUM_ROWS_WIDTH        = 2,
    parameter int NUM_COLS              = 4,
    parameter int NUM_COLS_WIDTH        = 2,
    parameter int CLOCK_DELAY           = 1000,
    parameter int CLOCK_DELAY_WIDTH     = 10,
    parameter int SETTLE_CLOCKS         = 50,
    parameter int DEBOUNCE_SCANS        = 4,
    parameter int DEBOUNCE_WIDTH        = 3,
    parameter int ROW_OUTPUT_ACTIVE_LOW = 0,
    parameter int COL_INPUT_ACTIVE_LOW  = 0
) (
    input  logic                               clk,
    input  logic                               i_rst,
    input  logic [NUM_COLS-1:0]                i_cols,
    input  logic                               i_key_ready,
    output logic [NUM_ROWS-1:0]                o_rows,
    output logic                               o_key_valid,
    output logic [NUM_ROWS_WIDTH+NUM_COLS_WIDTH-1:0] o_key_code,
    output logic                               o_key_pressed,
    output logic [NUM_ROWS*NUM_COLS-1:0]       o_keys
);

    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam logic [NUM_COLS-1:0] COL_IDLE =
        (COL_INPUT_ACTIVE_LOW != 0) ? {NUM_COLS{1'b1}} : {NUM_COLS{1'b0}};

    scan_state_t                state;
    logic [CLOCK_DELAY_WIDTH-1:0] timer;
    logic [NUM_ROWS_WIDTH-1:0]  row;
    logic [NUM_ROWS-1:0]        row_onehot;
    logic [NUM_COLS-1:0]        cols_meta, cols_sync, cols_norm;
    logic [NUM_COLS-1:0]        pending, remaining, row_keys, row_changes;
    logic [NUM_COLS_WIDTH-1:0]  first_col, next_col, cur_col;
    logic [NUM_KEYS-1:0]        keys, changed;
    logic                       sample_now, row_ghost;

    // Row drive: decoded one-hot, inverted for active-low boards.
    binary_decoder #(.WIDTH(NUM_ROWS_WIDTH), .OUTPUTS(NUM_ROWS)) u_row_dec (
        .sel    (row),
        .onehot (row_onehot)
    );
    assign o_rows = (ROW_OUTPUT_ACTIVE_LOW != 0) ? ~row_onehot : row_onehot;

    // Two-flop synchronizer; reset to the idle (not pressed) level.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            cols_meta <= COL_IDLE;
            cols_sync <= COL_IDLE;
        end else begin
            cols_meta <= i_cols;
            cols_sync <= cols_meta;
        end
    end

    assign cols_norm = (COL_INPUT_ACTIVE_LOW != 0) ? ~cols_sync : cols_sync;

`ifdef KEY_MATRIX_GHOST_REJECT_EN
    logic [NUM_COLS-1:0] other_cols;

    // Columns held down in any row other than the one being driven.
    always_comb begin
        other_cols = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row != NUM_ROWS_WIDTH'(r)) other_cols |= keys[r*NUM_COLS +: NUM_COLS];
        end
    end

    assign row_ghost = ((cols_norm & (cols_norm - NUM_COLS'(1))) != '0) &&
                       ((cols_norm & other_cols) != '0);
`else
    assign row_ghost = 1'b0;
`endif

    assign sample_now = (state == SCAN) &&
                        (timer == CLOCK_DELAY_WIDTH'(SETTLE_CLOCKS)) && !row_ghost;

    // One debouncer per key, enabled only while its row is sampled.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
            .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
        ) u_deb (
            .clk       (clk),
            .i_rst     (i_rst),
            .sample_en (sample_now && (row == NUM_ROWS_WIDTH'(k / NUM_COLS))),
            .sample    (cols_norm[k % NUM_COLS]),
            .state     (keys[k]),
            .changed   (changed[k])
        );
    end

    assign o_keys = keys;

    // Debounced state and flip pulses of the currently driven row.
    always_comb begin
        row_keys    = '0;
        row_changes = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row == NUM_ROWS_WIDTH'(r)) begin
                row_keys    = keys[r*NUM_COLS +: NUM_COLS];
                row_changes = changed[r*NUM_COLS +: NUM_COLS];
            end
        end
    end

    assign cur_col   = o_key_code[NUM_COLS_WIDTH-1:0];
    assign remaining = pending & ~(NUM_COLS'(1) << cur_col);
    assign first_col = NUM_COLS_WIDTH'(lowest_set_bit(32'(row_changes)));
    assign next_col  = NUM_COLS_WIDTH'(lowest_set_bit(32'(remaining)));

    // Scan/report FSM with registered event outputs.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state         <= SCAN;
            timer         <= '0;
            row           <= '0;
            pending       <= '0;
            o_key_valid   <= 1'b0;
            o_key_code    <= '0;
            o_key_pressed <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (timer == CLOCK_DELAY_WIDTH'(CLOCK_DELAY - 1)) begin
                        timer <= '0;
                        row   <= (row == NUM_ROWS_WIDTH'(NUM_ROWS - 1)) ? '0 : row + NUM_ROWS_WIDTH'(1);
                    end else begin
                        timer <= timer + CLOCK_DELAY_WIDTH'(1);
                    end
                    // Key state flips on this edge, so the new level is the inverse of row_keys.
                    if (sample_now && (row_changes != '0)) begin
                        pending       <= row_changes;
                        o_key_valid   <= 1'b1;
                        o_key_code    <= {row, first_col};
                        o_key_pressed <= ~row_keys[first_col];
                        state         <= REPORT;
                    end
                end
                REPORT: begin
                    if (o_key_valid && i_key_ready) begin
                        pending <= remaining;
                        if (remaining != '0) begin
                            o_key_code    <= {row, next_col};
                            o_key_pressed <= row_keys[next_col];
                        end else begin
                            o_key_valid <= 1'b0;
                            state       <= SCAN;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: 4x4 matrix, CLOCK_DELAY=20,
// SETTLE_CLOCKS=5, DEBOUNCE_SCANS=3, active-high rows and columns.
module tb_key_matrix_scan;

    logic        clk;
    logic        i_rst;
    logic [3:0]  i_cols;
    logic        i_key_ready;
    logic [3:0]  o_rows;
    logic        o_key_valid;
    logic [3:0]  o_key_code;
    logic        o_key_pressed;
    logic [15:0] o_keys;

    logic [15:0] phys;          // physically closed switches, bit row*4+col
    logic [4:0]  ev_q[$];       // accepted events {code, pressed}
    int          errors = 0;
    int          checks = 0;

    key_matrix_scan #(
        .NUM_ROWS(4), .NUM_ROWS_WIDTH(2), .NUM_COLS(4), .NUM_COLS_WIDTH(2),
        .CLOCK_DELAY(20), .CLOCK_DELAY_WIDTH(10), .SETTLE_CLOCKS(5),
        .DEBOUNCE_SCANS(3), .DEBOUNCE_WIDTH(3),
        .ROW_OUTPUT_ACTIVE_LOW(0), .COL_INPUT_ACTIVE_LOW(0)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_cols        (i_cols),
        .i_key_ready   (i_key_ready),
        .o_rows        (o_rows),
        .o_key_valid   (o_key_valid),
        .o_key_code    (o_key_code),
        .o_key_pressed (o_key_pressed),
        .o_keys        (o_keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: columns read the closed switches of every driven row.
    function automatic logic [3:0] matrix_cols(input logic [3:0] rows, input logic [15:0] sw);
        logic [3:0] c;
        c = '0;
        for (int r = 0; r < 4; r++) if (rows[r]) c |= sw[r*4 +: 4];
        return c;
    endfunction

    assign i_cols = matrix_cols(o_rows, phys);

    // Record every handshake; sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!i_rst && o_key_valid && i_key_ready) ev_q.push_back({o_key_code, o_key_pressed});
    end

    task automatic wait_row_start(input logic [3:0] target);
        int n;
        n = 0;
        while (o_rows === target && n < 200) begin @(posedge clk); #1; n++; end
        while (o_rows !== target && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (o_rows !== target) begin
            errors++;
            $display("FAIL wait_row: o_rows=%b required %b", o_rows, target);
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (o_key_valid !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (o_key_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: o_key_valid=%b required 1", o_key_valid);
        end
    endtask

    task automatic test_reset();
        int bad;
        i_rst = 1'b1; i_key_ready = 1'b1; phys = '0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        checks++; if (o_rows !== 4'b0001) begin errors++; $display("FAIL rst_rows: got %b required 0001", o_rows); end
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", o_key_valid); end
        checks++; if (o_key_code !== 4'b0000) begin errors++; $display("FAIL rst_code: got %b required 0000", o_key_code); end
        checks++; if (o_key_pressed !== 1'b0) begin errors++; $display("FAIL rst_pressed: got %b required 0", o_key_pressed); end
        checks++; if (o_keys !== 16'h0000) begin errors++; $display("FAIL rst_keys: got %h required 0000", o_keys); end
        bad = 0;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            if (o_rows !== 4'b0001 || o_key_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL row0_hold: bad cycles=%0d required 0", bad); end
        @(posedge clk); #1;
        checks++; if (o_rows !== 4'b0010) begin errors++; $display("FAIL row1_at_20: got %b required 0010", o_rows); end
        bad = 0;
        repeat (59) begin
            @(posedge clk); #1;
            if (o_key_valid !== 1'b0) bad++;
        end
        checks++; if (o_rows !== 4'b1000) begin errors++; $display("FAIL row3_at_79: got %b required 1000", o_rows); end
        @(posedge clk); #1;
        checks++; if (o_rows !== 4'b0001) begin errors++; $display("FAIL row0_at_80: got %b required 0001", o_rows); end
        checks++; if (bad != 0 || ev_q.size() != 0) begin errors++; $display("FAIL idle_no_event: valid cycles=%0d events=%0d required 0", bad, ev_q.size()); end
    endtask

    task automatic test_press_release();
        ev_q.delete();
        phys[9] = 1'b1;
        repeat (340) @(posedge clk);
        #1;
        checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL press_count: got %0d required 1", ev_q.size()); end
        if (ev_q.size() >= 1) begin
            checks++; if (ev_q[0] !== 5'b10011) begin errors++; $display("FAIL press_event: got %b required 10011", ev_q[0]); end
        end
        checks++; if (o_keys !== 16'h0200) begin errors++; $display("FAIL press_keys: got %h required 0200", o_keys); end
        ev_q.delete();
        phys[9] = 1'b0;
        repeat (340) @(posedge clk);
        #1;
        checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL release_count: got %0d required 1", ev_q.size()); end
        if (ev_q.size() >= 1) begin
            checks++; if (ev_q[0] !== 5'b10010) begin errors++; $display("FAIL release_event: got %b required 10010", ev_q[0]); end
        end
        checks++; if (o_keys !== 16'h0000) begin errors++; $display("FAIL release_keys: got %h required 0000", o_keys); end
    endtask

    task automatic test_glitch();
        wait_row_start(4'b0010);
        ev_q.delete();
        phys[7] = 1'b1;
        repeat (160) @(posedge clk);
        #1 phys[7] = 1'b0;
        repeat (340) @(posedge clk);
        #1;
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d required 0", ev_q.size()); end
        checks++; if (o_keys !== 16'h0000) begin errors++; $display("FAIL glitch_keys: got %h required 0000", o_keys); end
    endtask

    task automatic test_back_to_back();
        int bad;
        i_key_ready = 1'b0;
        ev_q.delete();
        phys = 16'h0005;
        wait_valid();
        checks++; if (o_key_code !== 4'b0000 || o_key_pressed !== 1'b1) begin errors++; $display("FAIL stall_first: code=%b pressed=%b required 0000/1", o_key_code, o_key_pressed); end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (o_key_valid !== 1'b1 || o_key_code !== 4'b0000 || o_rows !== 4'b0001) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: bad cycles=%0d required 0", bad); end
        i_key_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_key_valid !== 1'b1 || o_key_code !== 4'b0010 || o_key_pressed !== 1'b1) begin errors++; $display("FAIL second_event: valid=%b code=%b pressed=%b required 1/0010/1", o_key_valid, o_key_code, o_key_pressed); end
        @(posedge clk); #1;
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL after_last: valid=%b required 0", o_key_valid); end
        wait_row_start(4'b0010);
        checks++; if (ev_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d required 2", ev_q.size()); end
        phys = '0;
        repeat (340) @(posedge clk);
        #1;
        checks++; if (o_keys !== 16'h0000) begin errors++; $display("FAIL b2b_release_keys: got %h required 0000", o_keys); end
        ev_q.delete();
    endtask

    task automatic test_reset_in_report();
        i_key_ready = 1'b0;
        phys = 16'h0001;
        wait_valid();
        i_rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b required 0", o_key_valid); end
        checks++; if (o_keys !== 16'h0000) begin errors++; $display("FAIL rr_keys: got %h required 0000", o_keys); end
        i_rst = 1'b0;
        i_key_ready = 1'b1;
        ev_q.delete();
        repeat (165) @(posedge clk);
        #1;
        checks++; if (o_key_valid !== 1'b0) begin errors++; $display("FAIL rr_early: valid=%b required 0", o_key_valid); end
        @(posedge clk); #1;
        checks++; if (o_key_valid !== 1'b1 || o_key_code !== 4'b0000 || o_key_pressed !== 1'b1) begin errors++; $display("FAIL rr_repress: valid=%b code=%b pressed=%b required 1/0000/1", o_key_valid, o_key_code, o_key_pressed); end
        checks++; if (o_keys !== 16'h0001) begin errors++; $display("FAIL rr_keys_after: got %h required 0001", o_keys); end
        phys = '0;
        repeat (340) @(posedge clk);
        #1;
        ev_q.delete();
    endtask

    task automatic test_ghost();
        logic [15:0] exp_keys;
        int          exp_events;
`ifdef KEY_MATRIX_GHOST_REJECT_EN
        exp_keys   = 16'h0003;
        exp_events = 2;
`else
        exp_keys   = 16'h0033;
        exp_events = 4;
`endif
        wait_row_start(4'b0001);
        ev_q.delete();
        phys = 16'h0033;
        repeat (400) @(posedge clk);
        #1;
        checks++; if (o_keys !== exp_keys) begin errors++; $display("FAIL ghost_keys: got %h required %h", o_keys, exp_keys); end
        checks++; if (ev_q.size() != exp_events) begin errors++; $display("FAIL ghost_events: got %0d required %0d", ev_q.size(), exp_events); end
    endtask

    initial begin
        i_rst = 1'b1;
        i_key_ready = 1'b1;
        phys = '0;
        test_reset();
        test_press_release();
        test_glitch();
        test_back_to_back();
        test_reset_in_report();
        test_ghost();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
